// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

    typedef enum logic [2:0] {
        EV_NONE     = 3'd0,
        EV_MEMWAIT  = 3'd1,
        EV_REDIRECT = 3'd2,
        EV_LOADUSE  = 3'd3,
        EV_RAWSTALL = 3'd4,
        EV_IMISS    = 3'd5
    } hz_event_t;

    localparam int unsigned IFID   = 0;
    localparam int unsigned IDEX   = 1;
    localparam int unsigned EXMEM  = 2;
    localparam int unsigned MEMWB  = 3;
    localparam int unsigned NLATCH = 4;

    // Bubble mask covering latches 0..depth-1.
    function automatic logic [NLATCH-1:0] front_mask(input int unsigned depth);
        logic [NLATCH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NLATCH; i++) begin
            if (i < depth) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, latch/PC enables and stall counter out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REGW = 5,
    parameter int unsigned CNTW = 32
);
    logic [REGW-1:0] ifid_rs;
    logic [REGW-1:0] ifid_rt;
    logic            ifid_use_rs;
    logic            ifid_use_rt;
    logic [REGW-1:0] idex_wsel;
    logic            idex_regwen;
    logic            idex_memread;
    logic [REGW-1:0] exmem_wsel;
    logic            exmem_regwen;
    logic            dmem_req;
    logic            dhit;
    logic            ihit;
    logic            redirect;
    logic            pc_en;
    logic [3:0]      stall;
    logic [3:0]      flush;
    logic [CNTW-1:0] stall_cnt;

    modport master (
        output ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt,
        output idex_wsel, idex_regwen, idex_memread,
        output exmem_wsel, exmem_regwen,
        output dmem_req, dhit, ihit, redirect,
        input  pc_en, stall, flush, stall_cnt
    );

    modport slave (
        input  ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt,
        input  idex_wsel, idex_regwen, idex_memread,
        input  exmem_wsel, exmem_regwen,
        input  dmem_req, dhit, ihit, redirect,
        output pc_en, stall, flush, stall_cnt
    );
endinterface

// File: rtl/hazard_match.sv
// Source-vs-destination register match, gated by use flags, write enable and $0.
module hazard_match #(
    parameter int unsigned REGW = 5
) (
    input  logic [REGW-1:0] rs,
    input  logic [REGW-1:0] rt,
    input  logic            use_rs,
    input  logic            use_rt,
    input  logic [REGW-1:0] wsel,
    input  logic            wen,
    output logic            hit
);
    always_comb begin
        hit = 1'b0;
        if (wen && (wsel != '0)) begin
            hit = (use_rs && (rs == wsel)) || (use_rt && (rt == wsel));
        end
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Arbitrated hazard controller: priority-encoded events drive latch stall/flush and PC enable,
// with a load-use FSM, a pending-redirect register and a saturating stall counter.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter int unsigned FLUSH_DEPTH     = 2,
    parameter int unsigned FWD_EN          = 1,
    parameter int unsigned REGW            = 5,
    parameter int unsigned CNTW            = 32
) (
    input logic                    CLK,
    input logic                    RST,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam logic [2:0]        LU_LOAD    = 3'(LOAD_USE_CYCLES - 1);
    localparam logic [NLATCH-1:0] REDIR_MASK = front_mask(FLUSH_DEPTH);

    hz_state_t       state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic            hit_ex, hit_mem;
    logic            memwait, redir, loaduse, rawstall;
    hz_event_t       ev;
    logic            pc_en_o;
    logic [3:0]      stall_o, flush_o;

    hazard_match #(.REGW(REGW)) u_match_ex (
        .rs     (hz.ifid_rs),
        .rt     (hz.ifid_rt),
        .use_rs (hz.ifid_use_rs),
        .use_rt (hz.ifid_use_rt),
        .wsel   (hz.idex_wsel),
        .wen    (hz.idex_regwen),
        .hit    (hit_ex)
    );

    hazard_match #(.REGW(REGW)) u_match_mem (
        .rs     (hz.ifid_rs),
        .rt     (hz.ifid_rt),
        .use_rs (hz.ifid_use_rs),
        .use_rt (hz.ifid_use_rt),
        .wsel   (hz.exmem_wsel),
        .wen    (hz.exmem_regwen),
        .hit    (hit_mem)
    );

    always_comb begin
        memwait  = hz.dmem_req && !hz.dhit;
        redir    = hz.redirect || pend_q;
        loaduse  = (hz.idex_memread && hit_ex) || (state_q == LU_STALL);
        rawstall = (FWD_EN == 0) && (hit_ex || hit_mem);

        ev = EV_NONE;
        if (memwait)       ev = EV_MEMWAIT;
        else if (redir)    ev = EV_REDIRECT;
        else if (loaduse)  ev = EV_LOADUSE;
        else if (rawstall) ev = EV_RAWSTALL;
        else if (!hz.ihit) ev = EV_IMISS;
    end

    always_comb begin
        pc_en_o = 1'b1;
        stall_o = '0;
        flush_o = '0;
        if (RST) begin
            pc_en_o = 1'b0;
            flush_o = '1;
        end else begin
            unique case (ev)
                EV_MEMWAIT: begin
                    pc_en_o        = 1'b0;
                    stall_o[IFID]  = 1'b1;
                    stall_o[IDEX]  = 1'b1;
                    stall_o[EXMEM] = 1'b1;
                    flush_o[MEMWB] = 1'b1;
                end
                EV_REDIRECT: flush_o = REDIR_MASK;
                EV_LOADUSE, EV_RAWSTALL: begin
                    pc_en_o       = 1'b0;
                    stall_o[IFID] = 1'b1;
                    flush_o[IDEX] = 1'b1;
                end
                EV_IMISS: begin
                    pc_en_o       = 1'b0;
                    flush_o[IFID] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // MEMWAIT freezes the load-use sequence so the bubble total is unaffected by waits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (ev)
            EV_MEMWAIT: pend_d = pend_q | hz.redirect;
            EV_REDIRECT: begin
                state_d = RUN;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
            EV_LOADUSE: begin
                if (state_q == LU_STALL) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = RUN;
                end else if (LOAD_USE_CYCLES > 1) begin
                    state_d = LU_STALL;
                    cnt_d   = LU_LOAD;
                end
            end
            default: ;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (!pc_en_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNTW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.pc_en     = pc_en_o;
    assign hz.stall     = stall_o;
    assign hz.flush     = flush_o;
    assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard controller for the 5-stage MIPS pipeline. It sits beside the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and drives their per-latch stall and flush enables plus the PC enable. It resolves, in one arbitrated unit:

- load-use stalls of configurable length
- RAW stalls when forwarding is disabled
- instruction and data memory wait states
- branch/jump redirects, with a redirect held pending across a memory wait

It also keeps a stall-cycle performance counter.

## Interface

Parameters:
- LOAD_USE_CYCLES, 1: bubbles inserted per load-use hazard, range 1–7.
- FLUSH_DEPTH, 2: number of front latches (index 0 upward) bubbled on a redirect, range 1–3.
- FWD_EN, 1: 1 means a forwarding unit exists. 0 means every RAW dependency against ID/EX or EX/MEM stalls.
- REGW, 5: register address width.
- CNTW, 32: width of the stall counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- ifid_rs, ifid_rt  in  REGW each  source registers of the instruction in IF/ID.
- ifid_use_rs, ifid_use_rt  in  1 each  the source is actually read.
- idex_wsel  in  REGW  destination of the ID/EX instruction.
- idex_regwen, idex_memread  in  1 each.
- exmem_wsel  in  REGW  destination of the EX/MEM instruction.
- exmem_regwen  in  1.
- dmem_req  in  1  the EX/MEM instruction is a load or store.
- dhit, ihit  in  1 each  memory ready.
- redirect  in  1  branch taken or jump resolved this cycle.
- pc_en  out  1  PC may update.
- stall  out  4  bit i holds latch i.
- flush  out  4  bit i loads a bubble into latch i.
- stall_cnt  out  CNTW  cycles with pc_en=0 since reset; saturates.

## Operation

- Register 0 never creates a hazard. A source only matches when its use flag is set.
- Events are evaluated combinationally each cycle, in strict priority order:
  1. MEMWAIT (dmem_req & ~dhit): stall=4'b0111, flush=4'b1000, pc_en=0. If redirect is also high, set pend_redir.
  2. REDIRECT (redirect | pend_redir): flush[FLUSH_DEPTH-1:0]=1, stall=0, pc_en=1. Clear pend_redir. Abort any load-use sequence by forcing the FSM to RUN with cnt=0.
  3. LOADUSE (idex_memread & idex_regwen & source match on idex_wsel, or FSM in LU_STALL): stall=4'b0001, flush=4'b0010, pc_en=0.
  4. RAWSTALL (only when FWD_EN=0; a source matches a regwen'd idex_wsel or exmem_wsel): same outputs as LOADUSE. It is re-evaluated every cycle and has no FSM state.
  5. IMISS (~ihit): pc_en=0, flush=4'b0001, stall=0.
  6. Otherwise: pc_en=1, stall=0, flush=0.
- FSM states are RUN and LU_STALL. cnt is a 3-bit counter.
  - RUN → LU_STALL when LOADUSE fires from RUN, no higher-priority event is active, and LOAD_USE_CYCLES>1. cnt is loaded with LOAD_USE_CYCLES-1.
  - In LU_STALL, cnt decrements each cycle that is neither MEMWAIT nor REDIRECT. LU_STALL → RUN on the cycle cnt==1 decrements.
  - MEMWAIT freezes cnt and the state. REDIRECT forces RUN.
  - Total load-use bubbles always equal LOAD_USE_CYCLES, independent of interleaved memory waits.
- stall_cnt increments on every non-reset cycle with pc_en=0 and holds at all-ones.

## Timing

- While RST is high and on the cycle after it falls:
  - Registered state is reset: FSM=RUN, cnt=0, pend_redir=0, stall_cnt=0.
  - While RST is high the outputs are forced to pc_en=0, stall=0, flush=4'b1111.
- All outputs are combinational from the inputs and registered state, and are valid in the same cycle. Zero latency from a hazard input to stall or flush.
- Registered state updates on the CLK rising edge.
- A redirect seen during MEMWAIT takes effect on the first cycle dhit=1. That cycle emits REDIRECT flushes, and pend_redir clears at the end of that cycle.
- A redirect and a load-use in the same cycle resolve to REDIRECT. The IF/ID instruction is wrong-path, so no bubble is inserted at ID/EX.
- RST asserted mid-LU_STALL or mid-MEMWAIT discards cnt and pend_redir on the next edge.

## Structure

- hazard_pkg (shared) holds:
  - typedef hz_state_t {RUN, LU_STALL}
  - latch index constants IFID=0, IDEX=1, EXMEM=2, MEMWB=3
  - typedef hz_event_t for the priority encoding, so the verifier can reuse it.
- A sub-module hazard_match computes source-vs-destination comparison with the reg-0 and use-flag gating. It is instantiated for ID/EX and EX/MEM.
- The top level holds the arbitration, FSM, pending register and counter.

## Test plan

- LOAD_USE_CYCLES=1: lw $5 in ID/EX, add reading $5 in IF/ID → one cycle with pc_en=0, stall=0001, flush=0010. Next cycle normal; stall_cnt=1.
- LOAD_USE_CYCLES=3, with dhit low for 2 cycles mid-sequence → exactly 3 load-use cycles plus 2 MEMWAIT cycles (stall=0111, flush=1000); stall_cnt=5.
- redirect during a 4-cycle MEMWAIT, FLUSH_DEPTH=2 → no flush during the wait. The cycle dhit rises has flush=0011 and pc_en=1, and pend_redir clears.
- Load-use on $0, and a load-use with ifid_use_rt=0 on an rt match → no stall.
- FWD_EN=0: addi $3 in EX/MEM, sub reading $3 in IF/ID → stall=0001, flush=0010 for 1 cycle. With FWD_EN=1, the same stimulus produces no stall.
- RST pulsed while in LU_STALL with cnt=2 → outputs return to 0/0000/1111 during reset. After release the FSM is RUN and stall_cnt=0.
